// File: rtl/product_accumulator.sv
// -----------------------------------------------------------------------------
// product_accumulator
//
// Sums LEN consecutive signed products from simple_multiplier into an AW-bit
// signed accumulator. When a burst is complete the total is held on acc_out
// with out_valid high until the consumer takes it with out_ready.
//
// Build option:
//   ACC_SAT_EN  - when defined, a signed overflow clamps the accumulator to the
//                 most positive / most negative AW-bit value instead of wrapping.
//                 The sticky overflow flag is set either way.
//
// Parameters:
//   PW   product width (two's complement)
//   AW   accumulator width, AW >= PW
//   LEN  products per burst, LEN >= 1
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   clear      synchronous flush of the current burst (below rst in priority)
//   in_valid   p is valid this cycle
//   in_ready   block accepts a product this cycle (high while collecting)
//   p          signed product
//   out_valid  acc_out holds a completed burst sum
//   out_ready  consumer takes acc_out this cycle
//   acc_out    running partial sum while collecting, burst total while holding
//   of         sticky signed-overflow flag for the current burst
//   cnt        products accepted so far in the current burst
// -----------------------------------------------------------------------------
module product_accumulator #(
    parameter int PW  = 64,
    parameter int AW  = 72,
    parameter int LEN = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PW-1:0]        p,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [AW-1:0]        acc_out,
    output logic                 of,
    output logic [$clog2(LEN):0] cnt
);

    localparam int CW = $clog2(LEN) + 1;

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t        state_reg;
    logic [AW-1:0] acc_reg;
    logic [CW-1:0] cnt_reg;
    logic          of_reg;

    logic [AW-1:0] p_ext;
    logic [AW-1:0] sum;
    logic [AW-1:0] acc_next;
    logic          ovf;
    logic          last;

    // Sign extension; when AW == PW the product is used as-is.
    generate
        if (AW > PW) begin : g_ext
            assign p_ext = {{(AW-PW){p[PW-1]}}, p};
        end else begin : g_noext
            assign p_ext = p;
        end
    endgenerate

    assign sum  = acc_reg + p_ext;
    // Overflow only possible when both operands share a sign and the sum's
    // sign departs from it.
    assign ovf  = (acc_reg[AW-1] == p_ext[AW-1]) && (sum[AW-1] != acc_reg[AW-1]);
    assign last = (cnt_reg == CW'(LEN - 1));

`ifdef ACC_SAT_EN
    always_comb begin
        acc_next = sum;
        if (ovf) begin
            // Direction of overflow follows the (common) operand sign.
            acc_next = acc_reg[AW-1] ? {1'b1, {(AW-1){1'b0}}}
                                     : {1'b0, {(AW-1){1'b1}}};
        end
    end
`else
    assign acc_next = sum;
`endif

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state_reg <= ACC;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            of_reg    <= 1'b0;
        end else begin
            case (state_reg)
                ACC: begin
                    if (in_valid) begin
                        acc_reg <= acc_next;
                        of_reg  <= of_reg | ovf;
                        if (last) begin
                            cnt_reg   <= '0;
                            state_reg <= HOLD;
                        end else begin
                            cnt_reg <= cnt_reg + CW'(1);
                        end
                    end
                end
                HOLD: begin
                    // Products offered here are ignored: one bubble per burst.
                    if (out_ready) begin
                        state_reg <= ACC;
                        acc_reg   <= '0;
                        of_reg    <= 1'b0;
                    end
                end
                default: state_reg <= ACC;
            endcase
        end
    end

    // Handshake flags decode straight from the state register.
    assign in_ready  = (state_reg == ACC);
    assign out_valid = (state_reg == HOLD);
    assign acc_out   = acc_reg;
    assign of        = of_reg;
    assign cnt       = cnt_reg;

endmodule

// File: tb/tb_product_accumulator.sv
// -----------------------------------------------------------------------------
// tb_product_accumulator
//
// Three instances: the default configuration (PW=64, AW=72, LEN=4), a narrow
// overflow-prone one (AW=64, LEN=2) and a single-product one (LEN=1).
// Directed table vectors, hand sequences for the multi-cycle corners, and
// randomized traffic compared against an exact-integer reference model.
// -----------------------------------------------------------------------------
module tb_product_accumulator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef ACC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    // default instance
    logic        m_rst = 1'b1, m_clear = 1'b0, m_in_valid = 1'b0, m_out_ready = 1'b0;
    logic        m_in_ready, m_out_valid, m_of;
    logic [63:0] m_p = '0;
    logic [71:0] m_acc_out;
    logic [2:0]  m_cnt;

    // overflow instance (AW=64, LEN=2)
    logic        o_rst = 1'b1, o_clear = 1'b0, o_in_valid = 1'b0, o_out_ready = 1'b0;
    logic        o_in_ready, o_out_valid, o_of;
    logic [63:0] o_p = '0;
    logic [63:0] o_acc_out;
    logic [1:0]  o_cnt;

    // single-product instance (LEN=1)
    logic        s_rst = 1'b1, s_clear = 1'b0, s_in_valid = 1'b0, s_out_ready = 1'b0;
    logic        s_in_ready, s_out_valid, s_of;
    logic [63:0] s_p = '0;
    logic [71:0] s_acc_out;
    logic [0:0]  s_cnt;

    product_accumulator u_main (
        .clk(clk), .rst(m_rst), .clear(m_clear), .in_valid(m_in_valid),
        .in_ready(m_in_ready), .p(m_p), .out_valid(m_out_valid),
        .out_ready(m_out_ready), .acc_out(m_acc_out), .of(m_of), .cnt(m_cnt)
    );

    product_accumulator #(.PW(64), .AW(64), .LEN(2)) u_ov (
        .clk(clk), .rst(o_rst), .clear(o_clear), .in_valid(o_in_valid),
        .in_ready(o_in_ready), .p(o_p), .out_valid(o_out_valid),
        .out_ready(o_out_ready), .acc_out(o_acc_out), .of(o_of), .cnt(o_cnt)
    );

    product_accumulator #(.PW(64), .AW(72), .LEN(1)) u_one (
        .clk(clk), .rst(s_rst), .clear(s_clear), .in_valid(s_in_valid),
        .in_ready(s_in_ready), .p(s_p), .out_valid(s_out_valid),
        .out_ready(s_out_ready), .acc_out(s_acc_out), .of(s_of), .cnt(s_cnt)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------------------------------------------------------- vectors
    typedef struct {
        bit          rst;
        bit          clr;
        bit          v;
        logic [63:0] p;
        bit          ordy;
        bit          e_valid;
        logic [71:0] e_acc;
        bit          e_of;
        int          e_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkv(bit rst, bit clr, bit v, longint p, bit ordy,
                                 bit e_valid, longint e_acc, bit e_of, int e_cnt);
        vec_t r;
        r.rst = rst; r.clr = clr; r.v = v; r.p = 64'(p); r.ordy = ordy;
        r.e_valid = e_valid; r.e_acc = 72'(e_acc); r.e_of = e_of; r.e_cnt = e_cnt;
        return r;
    endfunction

    task automatic fill_vectors();
        //                 rst clr v  p      rdy  ev  acc    of cnt
        vecs.push_back(mkv(1, 0, 1, 123,   0,   0,  0,     0, 0)); // reset state
        // basic burst
        vecs.push_back(mkv(0, 0, 1, 1500,  1,   0,  1500,  0, 1));
        vecs.push_back(mkv(0, 0, 1, -345,  1,   0,  1155,  0, 2));
        vecs.push_back(mkv(0, 0, 1, 2064,  1,   0,  3219,  0, 3));
        vecs.push_back(mkv(0, 0, 1, -750,  1,   1,  2469,  0, 0));
        vecs.push_back(mkv(0, 0, 0, 0,     1,   0,  0,     0, 0));
        // backpressure, products offered during HOLD are ignored
        vecs.push_back(mkv(0, 0, 1, 1500,  0,   0,  1500,  0, 1));
        vecs.push_back(mkv(0, 0, 1, -345,  0,   0,  1155,  0, 2));
        vecs.push_back(mkv(0, 0, 1, 2064,  0,   0,  3219,  0, 3));
        vecs.push_back(mkv(0, 0, 1, -750,  0,   1,  2469,  0, 0));
        vecs.push_back(mkv(0, 0, 1, 999,   0,   1,  2469,  0, 0));
        vecs.push_back(mkv(0, 0, 1, 999,   0,   1,  2469,  0, 0));
        vecs.push_back(mkv(0, 0, 0, 0,     0,   1,  2469,  0, 0));
        vecs.push_back(mkv(0, 0, 1, 7,     1,   0,  0,     0, 0));
        vecs.push_back(mkv(0, 0, 0, 0,     0,   0,  0,     0, 0));
        // gapped input
        vecs.push_back(mkv(0, 0, 1, 2500,  0,   0,  2500,  0, 1));
        vecs.push_back(mkv(0, 0, 0, 0,     0,   0,  2500,  0, 1));
        vecs.push_back(mkv(0, 0, 0, 0,     0,   0,  2500,  0, 1));
        vecs.push_back(mkv(0, 0, 1, -2250, 0,   0,  250,   0, 2));
        vecs.push_back(mkv(0, 0, 0, 0,     0,   0,  250,   0, 2));
        vecs.push_back(mkv(0, 0, 0, 0,     0,   0,  250,   0, 2));
        vecs.push_back(mkv(0, 0, 1, 10,    0,   0,  260,   0, 3));
        vecs.push_back(mkv(0, 0, 0, 0,     0,   0,  260,   0, 3));
        vecs.push_back(mkv(0, 0, 0, 0,     0,   0,  260,   0, 3));
        vecs.push_back(mkv(0, 0, 1, 0,     0,   1,  260,   0, 0));
        vecs.push_back(mkv(0, 0, 0, 0,     1,   0,  0,     0, 0));
        // clear mid-burst drops the product offered with it
        vecs.push_back(mkv(0, 0, 1, 1500,  0,   0,  1500,  0, 1));
        vecs.push_back(mkv(0, 0, 1, 2064,  0,   0,  3564,  0, 2));
        vecs.push_back(mkv(0, 1, 1, 50,    0,   0,  0,     0, 0));
        vecs.push_back(mkv(0, 0, 1, 100,   0,   0,  100,   0, 1));
        vecs.push_back(mkv(0, 0, 1, -200,  0,   0,  -100,  0, 2));
        vecs.push_back(mkv(0, 0, 1, 300,   0,   0,  200,   0, 3));
        vecs.push_back(mkv(0, 0, 1, -400,  0,   1,  -200,  0, 0));
        vecs.push_back(mkv(0, 0, 0, 0,     1,   0,  0,     0, 0));
        // reset mid-burst
        vecs.push_back(mkv(0, 0, 1, 1500,  0,   0,  1500,  0, 1));
        vecs.push_back(mkv(0, 0, 1, 2064,  0,   0,  3564,  0, 2));
        vecs.push_back(mkv(1, 0, 1, 50,    0,   0,  0,     0, 0));
        vecs.push_back(mkv(0, 0, 1, 100,   0,   0,  100,   0, 1));
        vecs.push_back(mkv(0, 0, 1, -200,  0,   0,  -100,  0, 2));
        vecs.push_back(mkv(0, 0, 1, 300,   0,   0,  200,   0, 3));
        vecs.push_back(mkv(0, 0, 1, -400,  0,   1,  -200,  0, 0));
        vecs.push_back(mkv(0, 0, 0, 0,     1,   0,  0,     0, 0));
        // clear while holding discards the result
        vecs.push_back(mkv(0, 0, 1, 1,     0,   0,  1,     0, 1));
        vecs.push_back(mkv(0, 0, 1, 2,     0,   0,  3,     0, 2));
        vecs.push_back(mkv(0, 0, 1, 3,     0,   0,  6,     0, 3));
        vecs.push_back(mkv(0, 0, 1, 4,     0,   1,  10,    0, 0));
        vecs.push_back(mkv(0, 1, 0, 0,     0,   0,  0,     0, 0));
        // out_ready in ACC has no effect
        vecs.push_back(mkv(0, 0, 1, -5,    1,   0,  -5,    0, 1));
        vecs.push_back(mkv(0, 0, 0, 0,     1,   0,  -5,    0, 1));
        vecs.push_back(mkv(0, 1, 0, 0,     0,   0,  0,     0, 0));
    endtask

    // ----------------------------------------------------------- random run
    // Model: exact 128-bit integer sum, range-checked against the AW-bit
    // signed range after every accepted product.
    task automatic rand_run(input int which, input int n);
        int                 aw  = (which == 0) ? 72 : 64;
        int                 len = (which == 0) ? 4 : 2;
        logic signed [127:0] maxv = (128'sd1 <<< (aw - 1)) - 128'sd1;
        logic signed [127:0] minv = -(128'sd1 <<< (aw - 1));
        logic signed [127:0] span = 128'sd1 <<< aw;
        logic        [127:0] mask = (128'd1 << aw) - 128'd1;
        logic signed [127:0] acc = 0, exact;
        bit                  of_m = 0, hold = 0;
        int                  cnt_m = 0;
        bit                  rst, clr, v, ordy;
        logic [63:0]         p;
        logic [127:0]        a_acc, a_valid, a_ready, a_of, a_cnt;
        int                  bursts = 0;

        for (int i = 0; i < n; i++) begin
            rst  = (i == 0) || ($urandom_range(0, 99) == 0);
            clr  = ($urandom_range(0, 39) == 0);
            v    = ($urandom_range(0, 9) < 7);
            ordy = $urandom_range(0, 1) == 1;
            case ($urandom_range(0, 2))
                0:       p = 64'(longint'($urandom_range(0, 4000)) - 2000);
                1:       p = {$urandom, $urandom};
                default: p = $urandom_range(0, 1) == 1 ? 64'h7FFF_FFFF_FFFF_FFFF
                                                       : 64'h8000_0000_0000_0000;
            endcase
            if (which == 0) begin
                m_rst = rst; m_clear = clr; m_in_valid = v; m_p = p; m_out_ready = ordy;
            end else begin
                o_rst = rst; o_clear = clr; o_in_valid = v; o_p = p; o_out_ready = ordy;
            end
            @(posedge clk);
            if (rst || clr) begin
                acc = 0; of_m = 0; cnt_m = 0; hold = 0;
            end else if (!hold && v) begin
                exact = acc + $signed({{64{p[63]}}, p});
                if (exact > maxv) begin
                    of_m = 1; acc = SAT ? maxv : exact - span;
                end else if (exact < minv) begin
                    of_m = 1; acc = SAT ? minv : exact + span;
                end else begin
                    acc = exact;
                end
                cnt_m++;
                if (cnt_m == len) begin
                    hold = 1; cnt_m = 0;
                end
            end else if (hold && ordy) begin
                hold = 0; acc = 0; of_m = 0;
                bursts++;
            end
            #1;
            if (which == 0) begin
                a_acc = m_acc_out; a_valid = m_out_valid; a_ready = m_in_ready;
                a_of = m_of; a_cnt = m_cnt;
            end else begin
                a_acc = o_acc_out; a_valid = o_out_valid; a_ready = o_in_ready;
                a_of = o_of; a_cnt = o_cnt;
            end
            check($sformatf("rnd%0d.%0d acc", which, i), a_acc, acc & mask);
            check($sformatf("rnd%0d.%0d valid", which, i), a_valid, 128'(hold));
            check($sformatf("rnd%0d.%0d ready", which, i), a_ready, 128'(!hold));
            check($sformatf("rnd%0d.%0d of", which, i), a_of, 128'(of_m));
            check($sformatf("rnd%0d.%0d cnt", which, i), a_cnt, 128'(cnt_m));
        end
        $display("random run on instance %0d: %0d cycles, %0d bursts consumed", which, n, bursts);
        if (which == 0) begin
            m_rst = 0; m_clear = 0; m_in_valid = 0; m_out_ready = 0;
        end else begin
            o_rst = 0; o_clear = 0; o_in_valid = 0; o_out_ready = 0;
        end
    endtask

    // ------------------------------------------------------------ main test
    initial begin
        logic [63:0] e_pos, e_neg;
        logic [71:0] e72;

        fill_vectors();
        tick();
        tick();

        // directed vectors on the default instance
        for (int i = 0; i < vecs.size(); i++) begin
            m_rst = vecs[i].rst; m_clear = vecs[i].clr; m_in_valid = vecs[i].v;
            m_p = vecs[i].p; m_out_ready = vecs[i].ordy;
            tick();
            $display("vec %0d: rst=%0b clr=%0b v=%0b p=%0d rdy=%0b -> valid=%0b acc=%0d cnt=%0d of=%0b",
                     i, vecs[i].rst, vecs[i].clr, vecs[i].v, $signed(vecs[i].p), vecs[i].ordy,
                     m_out_valid, $signed(m_acc_out), m_cnt, m_of);
            check($sformatf("vec%0d valid", i), m_out_valid, vecs[i].e_valid);
            check($sformatf("vec%0d ready", i), m_in_ready, !vecs[i].e_valid);
            check($sformatf("vec%0d acc", i), m_acc_out, vecs[i].e_acc);
            check($sformatf("vec%0d of", i), m_of, vecs[i].e_of);
            check($sformatf("vec%0d cnt", i), m_cnt, 128'(vecs[i].e_cnt));
        end
        m_rst = 0; m_clear = 0; m_in_valid = 0; m_out_ready = 0;

        rand_run(0, 400);

        // overflow instance: positive overflow
        o_rst = 0;
        tick();
        check("ov reset acc", o_acc_out, 64'h0);
        check("ov reset ready", o_in_ready, 1'b1);
        o_in_valid = 1; o_p = 64'h7FFF_FFFF_FFFF_FFFF;
        tick();
        check("ov pos first acc", o_acc_out, 64'h7FFF_FFFF_FFFF_FFFF);
        check("ov pos first of", o_of, 1'b0);
        check("ov pos first cnt", o_cnt, 2'd1);
        tick();
        e_pos = SAT ? 64'h7FFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFE;
        $display("ov positive: acc=%0h of=%0b valid=%0b", o_acc_out, o_of, o_out_valid);
        check("ov pos acc", o_acc_out, e_pos);
        check("ov pos of", o_of, 1'b1);
        check("ov pos valid", o_out_valid, 1'b1);
        o_in_valid = 0; o_out_ready = 1;
        tick();
        check("ov pos consumed of", o_of, 1'b0);
        check("ov pos consumed acc", o_acc_out, 64'h0);
        check("ov pos consumed valid", o_out_valid, 1'b0);
        // negative overflow
        o_out_ready = 0; o_in_valid = 1; o_p = 64'h8000_0000_0000_0000;
        tick();
        check("ov neg first of", o_of, 1'b0);
        o_p = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        e_neg = SAT ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
        $display("ov negative: acc=%0h of=%0b valid=%0b", o_acc_out, o_of, o_out_valid);
        check("ov neg acc", o_acc_out, e_neg);
        check("ov neg of", o_of, 1'b1);
        o_in_valid = 0; o_clear = 1;
        tick();
        check("ov neg cleared of", o_of, 1'b0);
        check("ov neg cleared valid", o_out_valid, 1'b0);
        o_clear = 0;

        rand_run(1, 400);

        // LEN = 1
        s_rst = 0;
        tick();
        check("one reset ready", s_in_ready, 1'b1);
        s_in_valid = 1; s_p = 64'hFFFF_FFFF_FFFF_FEA7;
        tick();
        e72 = -72'sd345;
        $display("len1: p=-345 -> acc=%0d valid=%0b", $signed(s_acc_out), s_out_valid);
        check("one acc", s_acc_out, e72);
        check("one valid", s_out_valid, 1'b1);
        check("one cnt", s_cnt, 1'b0);
        s_p = 64'd5;
        tick();
        check("one held acc", s_acc_out, e72);
        s_out_ready = 1;
        tick();
        check("one consumed valid", s_out_valid, 1'b0);
        check("one consumed acc", s_acc_out, 72'd0);
        s_out_ready = 0;
        tick();
        check("one second acc", s_acc_out, 72'd5);
        check("one second valid", s_out_valid, 1'b1);
        s_in_valid = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
